// File: rtl/prince_sbox_cms_ctrl.sv
// prince_sbox_cms_ctrl
// Sequencer for one shared PRINCE S-layer pass through an external masked
// (CMS) S-box. The block issues the 16 nibbles of the shared state one per
// cycle when fresh randomness is available. It tracks in-flight issues
// through a LATENCY-deep tag line and collects the S-box results into the
// result register. The shares are only routed by this block and are never
// combined with one another.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle request, accepted only in IDLE
//   state_in    shared input state; share s at [64*s +: 64]
//   busy, done  busy in ISSUE/DRAIN; done pulses for one cycle
//   state_out   result register, same layout as state_in
//   rnd_valid / rnd_in / rnd_ready   fresh-randomness handshake
//   sbox_in / sbox_rnd               issue to the S-box (zero when idle)
//   sbox_out    S-box result, valid LATENCY cycles after issue
//   abort       synchronous cancel, only when PRINCE_CMS_CTRL_ABORT_EN is defined
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing nibble idx whenever rnd_valid is high
// DRAIN | all 16 issued, waiting for the remaining captures
// DONE  | one-cycle done pulse

module prince_sbox_cms_ctrl #(
  parameter int NSHARES = 3,
  parameter int LATENCY = 2,
  parameter int RND_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [64*NSHARES-1:0]  state_in,
  output logic                   busy,
  output logic                   done,
  output logic [64*NSHARES-1:0]  state_out,
  input  logic                   rnd_valid,
  input  logic [RND_W-1:0]       rnd_in,
  output logic                   rnd_ready,
  output logic [4*NSHARES-1:0]   sbox_in,
  output logic [RND_W-1:0]       sbox_rnd,
  input  logic [4*NSHARES-1:0]   sbox_out
`ifdef PRINCE_CMS_CTRL_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [64*NSHARES-1:0]   in_buf;
  logic [64*NSHARES-1:0]   result;
  logic [3:0]              idx;
  logic [4:0]              cap_cnt;
  logic [LATENCY-1:0]      pv;
  logic [3:0]              pidx [LATENCY];
  logic                    issue;
  logic                    start_acc;
  logic                    capture;
  logic                    abort_hit;

`ifdef PRINCE_CMS_CTRL_ABORT_EN
  assign abort_hit = abort && ((state == ISSUE) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign start_acc = (state == IDLE) && start;
  assign capture   = pv[LATENCY-1];
  assign state_out = result;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (abort_hit)                   state_nxt = IDLE;
        else if (issue && idx == 4'd15)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort_hit)                         state_nxt = IDLE;
        else if (capture && cap_cnt == 5'd15)  state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs; sbox_in/sbox_rnd are forced to zero on non-issue cycles
  always_comb begin
    issue     = (state == ISSUE) && rnd_valid;
    busy      = (state == ISSUE) || (state == DRAIN);
    done      = (state == DONE);
    rnd_ready = issue;
    sbox_in   = '0;
    sbox_rnd  = '0;
    if (issue) begin
      sbox_rnd = rnd_in;
      for (int s = 0; s < NSHARES; s++)
        sbox_in[4*s +: 4] = in_buf[64*s + 4*int'(idx) +: 4];
    end
  end

  // datapath: input buffer, issue index, tag line, capture counter, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_buf  <= '0;
      result  <= '0;
      idx     <= '0;
      cap_cnt <= '0;
      pv      <= '0;
      for (int i = 0; i < LATENCY; i++) pidx[i] <= '0;
    end else begin
      // tag line advances every cycle; stall cycles insert bubbles
      for (int i = LATENCY-1; i > 0; i--) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      pv[0]   <= issue;
      pidx[0] <= idx;

      if (start_acc) begin
        in_buf  <= state_in;
        idx     <= '0;
        cap_cnt <= '0;
      end
      if (issue) idx <= idx + 4'd1;
      if (capture) begin
        cap_cnt <= cap_cnt + 5'd1;
        for (int s = 0; s < NSHARES; s++)
          result[64*s + 4*int'(pidx[LATENCY-1]) +: 4] <= sbox_out[4*s +: 4];
      end
      if (abort_hit) begin
        idx     <= '0;
        cap_cnt <= '0;
        pv      <= '0;
        result  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prince_sbox_cms_ctrl.sv
module tb_prince_sbox_cms_ctrl;
  localparam int NS  = 3;
  localparam int LAT = 2;
  localparam int RW  = 8;
  localparam logic [191:0] XVEC = {128'h0, 64'h0123456789ABCDEF};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [191:0]  state_in = '0;
  logic          rnd_valid = 1'b0;
  logic [RW-1:0] rnd_in = '0;
  logic          busy, done, rnd_ready;
  logic [191:0]  state_out;
  logic [11:0]   sbox_in, sbox_out;
  logic [RW-1:0] sbox_rnd;
`ifdef PRINCE_CMS_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  int ncmp = 0;
  int nerr = 0;
  bit identity = 1'b1;
  logic [11:0] pipe [LAT];

  always #5 clk = ~clk;

  prince_sbox_cms_ctrl #(.NSHARES(NS), .LATENCY(LAT), .RND_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out),
    .rnd_valid(rnd_valid), .rnd_in(rnd_in), .rnd_ready(rnd_ready),
    .sbox_in(sbox_in), .sbox_rnd(sbox_rnd), .sbox_out(sbox_out)
`ifdef PRINCE_CMS_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hB; 4'h1: sb = 4'hF; 4'h2: sb = 4'h3; 4'h3: sb = 4'h2;
      4'h4: sb = 4'hA; 4'h5: sb = 4'hC; 4'h6: sb = 4'h9; 4'h7: sb = 4'h1;
      4'h8: sb = 4'h6; 4'h9: sb = 4'h7; 4'hA: sb = 4'h8; 4'hB: sb = 4'h0;
      4'hC: sb = 4'hE; 4'hD: sb = 4'h5; 4'hE: sb = 4'hD; default: sb = 4'h4;
    endcase
  endfunction

  // external S-box: identity pass-through, or unmask/substitute/remask
  function automatic logic [11:0] sbox_model(input logic [11:0] i, input logic [7:0] r, input bit id);
    logic [3:0] y;
    if (id) return i;
    y = sb(i[3:0] ^ i[7:4] ^ i[11:8]);
    return {r[7:4], r[3:0], y ^ r[3:0] ^ r[7:4]};
  endfunction

  function automatic logic [63:0] xsh(input logic [191:0] d);
    return d[63:0] ^ d[127:64] ^ d[191:128];
  endfunction

  function automatic logic [63:0] slayer(input logic [191:0] d);
    logic [63:0] x, r;
    x = xsh(d);
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(x[4*i +: 4]);
    return r;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= sbox_model(sbox_in, sbox_rnd, identity);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sbox_out = pipe[LAT-1];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: rnd always valid, 1: fixed stall after nibble st_after, 2: random stalls
  task automatic run_op(input logic [191:0] din, input int mode, input int st_after,
                        input int st_len, output int lat, output logic [191:0] res);
    int issued, stalls, c, sl;
    bit got;
    logic [11:0] e;
    @(posedge clk); #1;
    start = 1'b1; state_in = din; rnd_valid = 1'b0;
    issued = 0; stalls = 0; c = 0; sl = 0; got = 1'b0;
    while (!got && c < 300) begin
      @(posedge clk); #1;
      start = 1'b0; c++;
      rnd_valid = 1'b1;
      if (mode == 1 && issued == st_after + 1 && sl < st_len) begin
        rnd_valid = 1'b0; sl++;
      end
      if (mode == 2 && $urandom_range(0, 3) == 0) rnd_valid = 1'b0;
      rnd_in = RW'($urandom);
      #2;
      if (issued < 16) begin
        chk("busy_issue", 192'(busy), 192'(1));
        chk("rnd_ready", 192'(rnd_ready), 192'(rnd_valid));
        if (rnd_valid) begin
          for (int s = 0; s < NS; s++) e[4*s +: 4] = din[64*s + 4*issued +: 4];
          chk("sbox_rnd", 192'(sbox_rnd), 192'(rnd_in));
          chk("sbox_in", 192'(sbox_in), 192'(e));
          issued++;
        end else begin
          chk("sbox_in_stall", 192'(sbox_in), 192'(0));
          chk("sbox_rnd_stall", 192'(sbox_rnd), 192'(0));
          stalls++;
        end
      end else begin
        chk("rnd_ready_drain", 192'(rnd_ready), 192'(0));
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", 192'(got), 192'(1));
    chk("latency", 192'(c), 192'(16 + stalls + LAT + 1));
    lat = c;
    res = state_out;
    @(posedge clk); #3;
    chk("done_single", 192'(done), 192'(0));
    chk("idle_busy", 192'(busy), 192'(0));
    chk("result_hold", state_out, res);
  endtask

  initial begin
    int lat, ndone, last;
    logic [191:0] din, res;

    // reset state
    rnd_valid = 1'b1;
    #3;
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    chk("rst_rnd_ready", 192'(rnd_ready), 192'(0));
    chk("rst_sbox_in", 192'(sbox_in), 192'(0));
    chk("rst_sbox_rnd", 192'(sbox_rnd), 192'(0));
    chk("rst_state_out", state_out, 192'(0));
    @(negedge clk); rst_n = 1'b1;

    // identity S-box, no stalls
    identity = 1'b1;
    run_op(XVEC, 0, 0, 0, lat, res);
    chk("ident_lat19", 192'(lat), 192'(19));
    chk("ident_share0", 192'(res[63:0]), 192'(64'h0123456789ABCDEF));
    chk("ident_share12", 192'(res[191:64]), 192'(0));

    // five-cycle stall after nibble 7
    run_op(XVEC, 1, 7, 5, lat, res);
    chk("stall_lat24", 192'(lat), 192'(24));
    chk("stall_result", res, XVEC);

    // masked PRINCE S-box, random states and random stalls
    identity = 1'b0;
    for (int n = 0; n < 100; n++) begin
      din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_op(din, 2, 0, 0, lat, res);
      chk("slayer", 192'(xsh(res)), 192'(slayer(din)));
    end

    // reset pulse during DRAIN
    @(posedge clk); #1;
    din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start = 1'b1; state_in = din; rnd_valid = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("drain_busy", 192'(busy), 192'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 192'(busy), 192'(0));
    chk("rst_mid_done", 192'(done), 192'(0));
    chk("rst_mid_rnd_ready", 192'(rnd_ready), 192'(0));
    chk("rst_mid_sbox_in", 192'(sbox_in), 192'(0));
    chk("rst_mid_sbox_rnd", 192'(sbox_rnd), 192'(0));
    chk("rst_mid_state_out", state_out, 192'(0));
    @(negedge clk); rst_n = 1'b1;
    run_op(din, 2, 0, 0, lat, res);
    chk("post_rst_slayer", 192'(xsh(res)), 192'(slayer(din)));

    // start held high: one done per 20 cycles (19 + one IDLE cycle)
    identity = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; state_in = XVEC; rnd_valid = 1'b1;
    ndone = 0; last = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #3;
      if (done) begin
        ndone++;
        chk("held_spacing", 192'(c - last), 192'((ndone == 1) ? 19 : 20));
        chk("held_result", state_out, XVEC);
        last = c;
      end
    end
    chk("held_done_count", 192'(ndone), 192'(5));
    start = 1'b0;
    repeat (25) @(posedge clk);

`ifdef PRINCE_CMS_CTRL_ABORT_EN
    // abort after nibble 10 issued
    @(posedge clk); #1;
    start = 1'b1; state_in = XVEC; rnd_valid = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    #2;
    chk("abort_busy", 192'(busy), 192'(0));
    chk("abort_state_out", state_out, 192'(0));
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #3;
      if (done) ndone++;
    end
    chk("abort_no_done", 192'(ndone), 192'(0));
    run_op(XVEC, 0, 0, 0, lat, res);
    chk("abort_next_result", res, XVEC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/prince_sbox_cms_ctrl.md
PRINCE_SBOX_CMS_CTRL -- requirements
Module: prince_sbox_cms_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NSHARES, default 3: number of Boolean shares per state bit.
REQ-003 Parameter LATENCY, default 2: fixed S-box pipeline depth in cycles, legal range 1..8.
REQ-004 Parameter RND_W, default 8: fresh-randomness bits consumed per S-box evaluation.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to process state_in.
REQ-008 state_in  in  64*NSHARES  shared state, share s at bits [64*s +: 64], nibble i at [4*i +: 4] within a share.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when all 16 result nibbles are captured.
REQ-011 state_out  out  64*NSHARES  substituted shared state, same layout as state_in.
REQ-012 rnd_valid  in  1  rnd_in holds fresh randomness this cycle.
REQ-013 rnd_in  in  RND_W  fresh randomness.
REQ-014 rnd_ready  out  1  randomness consumed this cycle.
REQ-015 sbox_in  out  4*NSHARES  shared nibble to the S-box, share s at [4*s +: 4].
REQ-016 sbox_rnd  out  RND_W  randomness to the S-box.
REQ-017 sbox_out  in  4*NSHARES  shared S-box result, valid exactly LATENCY cycles after issue.
REQ-018 abort  in  1  synchronous cancel; present only with PRINCE_CMS_CTRL_ABORT_EN.

Function
REQ-019 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE: start=1 SHALL register state_in into an input buffer, clear issue index to 0, go to ISSUE; start outside IDLE SHALL be ignored.
REQ-021 ISSUE: one nibble issued per cycle when rnd_valid=1; an issue drives sbox_in = nibble[idx] of all shares, sbox_rnd = rnd_in, rnd_ready=1, then increments idx.
REQ-022 ISSUE with rnd_valid=0: no issue, rnd_ready=0, idx held; sbox_in and sbox_rnd SHALL be driven to zero on non-issue cycles.
REQ-023 After the issue with idx=15, go to DRAIN.
REQ-024 A LATENCY-deep shift line SHALL carry {valid, 4-bit idx} per issue; when its tail is valid, sbox_out SHALL be written into the result register at nibble idx, all shares.
REQ-025 A 5-bit capture counter SHALL count captures; on the 16th capture go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; state_out SHALL hold the result register, stable until the next capture after a later start.
REQ-027 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-028 Stalls in ISSUE SHALL leave bubbles in the shift line; the capture count still ends at exactly 16 and total latency is 16 + stall cycles + LATENCY + 1 (done) cycles from start.
REQ-029 start in the DONE cycle SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-030 No share recombination: share data SHALL never be XORed across shares inside the block.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, idx=0, capture count=0, shift line invalid, busy=0, done=0, rnd_ready=0, sbox_in=0, sbox_rnd=0, state_out=0, including mid-operation.
REQ-032 After reset release, the first start SHALL behave identically to a start after power-up.

Configuration
REQ-033 Macro PRINCE_CMS_CTRL_ABORT_EN defined: abort=1 in ISSUE or DRAIN SHALL return to IDLE next cycle, clear idx, counter and shift line, zero the result register, and suppress done; abort in IDLE/DONE ignored.
REQ-034 Macro undefined: abort port absent; operation completes only via REQ-025/026.

Verification
REQ-035 Identity S-box model, LATENCY=2, NSHARES=3, state_in shares 0x0123456789ABCDEF/0/0, rnd_valid=1 -> done at cycle 19 after start, state_out share0 0x0123456789ABCDEF.
REQ-036 PRINCE S-box behavioural model, random 3-share state -> XOR of state_out shares equals PRINCE S-layer of XOR of inputs; 100 random vectors.
REQ-037 rnd_valid low for 5 cycles after issuing nibble 7 -> rnd_ready low on those cycles, done 5 cycles later than in REQ-035, same result.
REQ-038 rst_n pulsed low during DRAIN -> all outputs 0 immediately; subsequent start produces correct result.
REQ-039 start held high continuously -> exactly one done per operation, no start accepted while busy or in DONE.
REQ-040 With PRINCE_CMS_CTRL_ABORT_EN: abort after nibble 10 issued -> no done, state_out=0, next start completes normally.
